// File: rtl/dcache_mem_pkg.sv
// Shared types and constants for the dcache memory-side blocks.
// Holds line geometry and the write-back buffer state encoding.
package dcache_mem_pkg;
   localparam int LINE_W   = 256;
   localparam int ADDR_W   = 32;
   localparam int LINE_OFF = 5;
   localparam int TAG_W    = ADDR_W - LINE_OFF;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RESP    = 3'd1,
      S_RD_MEM  = 3'd2,
      S_DRAIN   = 3'd3,
      S_RD_DONE = 3'd4
   } wbb_state_t;
endpackage

// File: rtl/wbb_fifo_cam.sv
// Circular line queue with a parallel tag CAM over the valid entries.
// Ports: push/pop/upd controls, wr_tag/wr_line, lk_tag lookup -> hit/hit_oh/hit_line, head, full/empty.
module wbb_fifo_cam #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 27,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              upd,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line,
   input  logic [TAG_W-1:0]  lk_tag,
   output logic              hit,
   output logic [DEPTH-1:0]  hit_oh,
   output logic [LINE_W-1:0] hit_line,
   output logic [TAG_W-1:0]  head_tag,
   output logic [LINE_W-1:0] head_line,
   output logic              full,
   output logic              empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]  valid;
   logic [TAG_W-1:0]  tag  [DEPTH];
   logic [LINE_W-1:0] line [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            valid[tail] <= 1'b1;
            tail        <= tail + 1'b1;
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload needs no reset: an entry is only visible through its valid bit.
   always_ff @(posedge clk) begin
      if (push) begin
         tag[tail]  <= wr_tag;
         line[tail] <= wr_line;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (upd && hit_oh[i]) line[i] <= wr_line;
      end
   end

   always_comb begin
      hit_oh   = '0;
      hit_line = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_oh[i] = valid[i] && (tag[i] == lk_tag);
         hit_line  = hit_line | (line[i] & {LINE_W{hit_oh[i]}});
      end
   end

   assign hit       = |hit_oh;
   assign head_tag  = tag[head];
   assign head_line = line[head];
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the dcache miss path and line memory.
// Ports: cache side enable/write/addr/data -> ack/data_o; mem_* request/ack; empty_o.
module dcache_wb_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = dcache_mem_pkg::ADDR_W,
   parameter int LINE_W = dcache_mem_pkg::LINE_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic              empty_o
);
   import dcache_mem_pkg::*;

   localparam int TW = ADDR_W - LINE_OFF;

   wbb_state_t        state, state_n;
   logic              ack_d;
   logic              ack_n;
   logic [LINE_W-1:0] data_n;
   logic              men_n;
   logic              mwe_n;
   logic [ADDR_W-1:0] madr_n;
   logic [LINE_W-1:0] mdat_n;

   logic              push, pop, upd;
   logic              hit, full, q_empty;
   logic [DEPTH-1:0]  hit_oh;
   logic [LINE_W-1:0] hit_line;
   logic [TW-1:0]     head_tag;
   logic [LINE_W-1:0] head_line;
   logic [TW-1:0]     req_tag;

   assign req_tag = addr_i[ADDR_W-1:LINE_OFF];

   wbb_fifo_cam #(
      .DEPTH  (DEPTH),
      .TAG_W  (TW),
      .LINE_W (LINE_W)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .pop       (pop),
      .upd       (upd),
      .wr_tag    (req_tag),
      .wr_line   (data_i),
      .lk_tag    (req_tag),
      .hit       (hit),
      .hit_oh    (hit_oh),
      .hit_line  (hit_line),
      .head_tag  (head_tag),
      .head_line (head_line),
      .full      (full),
      .empty     (q_empty)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         ack_o        <= 1'b0;
         ack_d        <= 1'b0;
         data_o       <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
      end else begin
         state        <= state_n;
         ack_o        <= ack_n;
         ack_d        <= ack_o;
         data_o       <= data_n;
         mem_enable_o <= men_n;
         mem_write_o  <= mwe_n;
         mem_addr_o   <= madr_n;
         mem_data_o   <= mdat_n;
      end
   end

   always_comb begin
      state_n = state;
      ack_n   = 1'b0;
      data_n  = data_o;
      men_n   = mem_enable_o;
      mwe_n   = mem_write_o;
      madr_n  = mem_addr_o;
      mdat_n  = mem_data_o;
      push    = 1'b0;
      pop     = 1'b0;
      upd     = 1'b0;
      unique case (state)
         S_IDLE: begin
            // The requester may still hold the acked request for two
            // cycles; draining is also held off so a follow-up refill
            // reaches memory ahead of the queued lines.
            if (!ack_o && !ack_d) begin
               if (enable_i && write_i && hit) begin
                  upd     = 1'b1;
                  state_n = S_RESP;
               end else if (enable_i && write_i && !full) begin
                  push    = 1'b1;
                  state_n = S_RESP;
               end else if (enable_i && !write_i && hit) begin
                  data_n  = hit_line;
                  state_n = S_RESP;
               end else if (enable_i && !write_i) begin
                  men_n   = 1'b1;
                  mwe_n   = 1'b0;
                  madr_n  = {req_tag, {LINE_OFF{1'b0}}};
                  state_n = S_RD_MEM;
               end else if (!q_empty) begin
                  men_n   = 1'b1;
                  mwe_n   = 1'b1;
                  madr_n  = {head_tag, {LINE_OFF{1'b0}}};
                  mdat_n  = head_line;
                  state_n = S_DRAIN;
               end
            end
         end
         S_RESP: begin
            ack_n   = 1'b1;
            state_n = S_IDLE;
         end
         S_RD_MEM: begin
            if (mem_ack_i) begin
               data_n  = mem_data_i;
               men_n   = 1'b0;
               state_n = S_RD_DONE;
            end
         end
         S_RD_DONE: begin
            ack_n   = 1'b1;
            state_n = S_IDLE;
         end
         S_DRAIN: begin
            if (mem_ack_i) begin
               pop     = 1'b1;
               men_n   = 1'b0;
               mwe_n   = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign empty_o = q_empty && (state == S_IDLE);
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer with a 10-cycle line memory model.
// Scoreboards read data and memory write order against bench-side expectations.
module tb_dcache_wb_buffer;
   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          enable_i;
   logic          write_i;
   logic [AW-1:0] addr_i;
   logic [LW-1:0] data_i;
   logic          ack_o;
   logic [LW-1:0] data_o;
   logic          mem_enable_o;
   logic          mem_write_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_data_o;
   logic          mem_ack_i;
   logic [LW-1:0] mem_data_i;
   logic          empty_o;

   always #5 clk_i = ~clk_i;

   dcache_wb_buffer #(.DEPTH(4), .ADDR_W(AW), .LINE_W(LW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .enable_i     (enable_i),
      .write_i      (write_i),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .ack_o        (ack_o),
      .data_o       (data_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_ack_i    (mem_ack_i),
      .mem_data_i   (mem_data_i),
      .empty_o      (empty_o)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [LW-1:0] d;
   } wr_t;

   logic [LW-1:0] wmem [int];
   wr_t           wr_seen [$];
   int            n_rd;
   int            mcnt;
   logic [AW-1:0] last_rd_addr;

   logic [LW-1:0] exp_q [$];
   wr_t           exp_wr_q [$];
   int            wr_chk;
   int            total;
   int            passes;
   int            fails;

   function automatic logic [LW-1:0] pat(input int i);
      return {8{16'hECFA, 16'(i)}};
   endfunction

   function automatic logic [LW-1:0] ln(input int k);
      return {8{16'hD0D0, 16'(k)}};
   endfunction

   function automatic logic [LW-1:0] mem_rd(input int i);
      if (wmem.exists(i)) return wmem[i];
      return pat(i);
   endfunction

   // Memory: ack 10 cycles after mem_enable_o rises, data with the ack.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcnt       <= 0;
         mem_ack_i  <= 1'b0;
         mem_data_i <= '0;
      end else begin
         mem_ack_i <= 1'b0;
         if (mem_enable_o && !mem_ack_i) begin
            if (mcnt == 9) begin
               mcnt      <= 0;
               mem_ack_i <= 1'b1;
               if (mem_write_o) begin
                  wmem[int'(mem_addr_o[10:5])] = mem_data_o;
                  wr_seen.push_back({mem_addr_o, mem_data_o});
               end else begin
                  mem_data_i   <= mem_rd(int'(mem_addr_o[10:5]));
                  n_rd         <= n_rd + 1;
                  last_rd_addr <= mem_addr_o;
               end
            end else begin
               mcnt <= mcnt + 1;
            end
         end else begin
            mcnt <= 0;
         end
      end
   end

   task automatic check(input string tag, input logic [LW-1:0] obs,
                        input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic w,
                         input logic [AW-1:0] a, input logic [LW-1:0] d,
                         output int lat);
      logic [LW-1:0] e;
      enable_i = 1'b1;
      write_i  = w;
      addr_i   = a;
      data_i   = d;
      lat      = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!ack_o && lat < 400);
      check({tag, "_ack"}, ack_o, 1);
      if (!w) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         check({tag, "_rdata"}, data_o, e);
      end
      enable_i = 1'b0;
   endtask

   task automatic wait_empty(input string tag);
      int n;
      n = 0;
      while (!empty_o && n < 1000) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_empty"}, empty_o, 1);
   endtask

   task automatic check_writes(input string tag);
      wr_t e;
      while (wr_chk < wr_seen.size()) begin
         if (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            check({tag, "_waddr"}, wr_seen[wr_chk].a, e.a);
            check({tag, "_wdata"}, wr_seen[wr_chk].d, e.d);
         end
         wr_chk++;
      end
      check({tag, "_wpend"}, exp_wr_q.size(), 0);
   endtask

   initial begin
      int lat;
      int b_wr;
      int b_rd;
      total    = 0;
      passes   = 0;
      fails    = 0;
      wr_chk   = 0;
      n_rd     = 0;
      rst_i    = 1'b1;
      enable_i = 1'b0;
      write_i  = 1'b0;
      addr_i   = '0;
      data_i   = '0;
      repeat (3) @(negedge clk_i);
      check("rst_empty", empty_o, 1);
      check("rst_ctl", {ack_o, mem_enable_o, mem_write_o}, 0);
      check("rst_data", data_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Single write into an empty buffer, then drain.
      exp_wr_q.push_back({32'h0000_0000, ln(1)});
      do_req("t1_wr", 1'b1, 32'h0000_0000, ln(1), lat);
      check("t1_lat", lat, 2);
      check("t1_nomem", mem_enable_o, 0);
      wait_empty("t1");
      check_writes("t1");
      check("t1_mem0", mem_rd(0), ln(1));

      // Refill read overtakes a queued eviction.
      b_wr = wr_seen.size();
      b_rd = n_rd;
      exp_wr_q.push_back({32'h0000_0200, ln(2)});
      do_req("t2_wr", 1'b1, 32'h0000_0200, ln(2), lat);
      exp_q.push_back(pat(32));
      do_req("t2_rd", 1'b0, 32'h0000_0400, '0, lat);
      check("t2_rdfirst", wr_seen.size() - b_wr, 0);
      check("t2_nrd", n_rd - b_rd, 1);
      wait_empty("t2");
      check_writes("t2");
      check("t2_mem16", mem_rd(16), ln(2));

      // Coalesced writes and a buffer hit.
      b_wr = wr_seen.size();
      b_rd = n_rd;
      exp_wr_q.push_back({32'h0000_0020, ln(4)});
      do_req("t3_wr1", 1'b1, 32'h0000_0020, ln(3), lat);
      do_req("t3_wr2", 1'b1, 32'h0000_0020, ln(4), lat);
      exp_q.push_back(ln(4));
      do_req("t3_rd", 1'b0, 32'h0000_0020, '0, lat);
      check("t3_nomemrd", n_rd - b_rd, 0);
      wait_empty("t3");
      check("t3_onewr", wr_seen.size() - b_wr, 1);
      check_writes("t3");
      check("t3_mem1", mem_rd(1), ln(4));

      // Five writes into a four-entry buffer.
      b_wr = wr_seen.size();
      for (int i = 0; i < 5; i++) begin
         exp_wr_q.push_back({32'h100 + 32'(i * 32), ln(10 + i)});
         do_req("t4_wr", 1'b1, 32'h100 + 32'(i * 32), ln(10 + i), lat);
         if (i < 4) check("t4_nodrain", wr_seen.size() - b_wr, 0);
      end
      check("t4_stall", wr_seen.size() - b_wr, 1);
      check("t4_lat", lat > 10, 1);
      wait_empty("t4");
      check_writes("t4");
      check("t4_mem12", mem_rd(12), ln(14));

      // Reset in the middle of a drain.
      b_wr = wr_seen.size();
      do_req("t5_wr", 1'b1, 32'h0000_0300, ln(20), lat);
      lat = 0;
      while (!mem_enable_o && lat < 100) begin
         @(negedge clk_i);
         lat++;
      end
      check("t5_drain", {mem_enable_o, mem_write_o}, 2'b11);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check("t5_ctl", {ack_o, mem_enable_o, mem_write_o}, 0);
      check("t5_addr", mem_addr_o, 0);
      check("t5_mdata", mem_data_o, 0);
      check("t5_empty", empty_o, 1);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (20) @(negedge clk_i);
      check("t5_nowr", wr_seen.size() - b_wr, 0);
      check("t5_mem24", mem_rd(24), pat(24));

      // Miss read while another line is queued.
      b_wr = wr_seen.size();
      b_rd = n_rd;
      exp_wr_q.push_back({32'h0000_0000, ln(30)});
      do_req("t6_wr", 1'b1, 32'h0000_0000, ln(30), lat);
      exp_q.push_back(pat(2));
      do_req("t6_rd", 1'b0, 32'h0000_0040, '0, lat);
      check("t6_raddr", last_rd_addr, 32'h40);
      check("t6_nrd", n_rd - b_rd, 1);
      check("t6_rdfirst", wr_seen.size() - b_wr, 0);
      wait_empty("t6");
      check_writes("t6");
      check("t6_mem0", mem_rd(0), ln(30));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
